apb_uart_fifo_regs: RTL and testbench
=====================================

Name: apb_uart_fifo_regs

Overview:
- Next-generation APB3 register front-end for the UART core, with parametrised-depth TX and RX FIFOs, level and watermark status, a receive-idle timeout, and a maskable interrupt.
- Sits between the APB fabric and a byte-level UART transceiver core.
- Owns all configuration registers and sticky error flags.
- The transceiver only sees a valid/ready TX stream, an RX pulse stream, and static line configuration.

Parameters:
- TX_DEPTH_LOG2, 4, TX FIFO depth = 2**TX_DEPTH_LOG2; legal range 1..7.
- RX_DEPTH_LOG2, 4, RX FIFO depth = 2**RX_DEPTH_LOG2; legal range 1..7.
- TO_SHIFT, 4, RX timeout prescale; timeout fires after {TIMEOUT, TO_SHIFT zeros} PCLK cycles.
- FIXEDMODE, 0, 1 = line config comes from the parameters below and CTRL writes are ignored.
- BAUD_VALUE, 0, fixed 13-bit baud value.
- BAUD_VAL_FRCTN, 0, fixed fraction (0..7).
- PRG_BIT8, 0, fixed bit8.
- PRG_PARITY, 0, fixed parity: 0 = none, 1 = odd, 2 = even.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- PADDR  in  6  byte address; decode uses PADDR[5:2].
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data, combinational during the access phase.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error response, valid in the access phase only.
- tx_data  out  8  TX FIFO head.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  core accepts the byte when tx_valid & tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe per received byte.
- rx_parity_err  in  1  qualified by rx_valid.
- rx_framing_err  in  1  qualified by rx_valid.
- baud_val  out  13  baud divisor to the core.
- baudval_fraction  out  3  fractional baud value to the core.
- bit8  out  1  line config: 8 data bits when 1.
- parity_en  out  1  line config: parity enabled when 1.
- odd_n_even  out  1  line config: odd parity when 1.
- irq  out  1  registered interrupt, level-sensitive.

Behaviour:
- Clock and reset:
  - Single clock PCLK; asynchronous active-low reset PRESETN, asserted asynchronously.
  - Reset clears FIFOs, all registers, the timeout counter and irq.
  - Reset values: tx_valid = 0, PRDATA = 0, baud_val = 0 (FIXEDMODE = 0) or the parameter values (FIXEDMODE = 1).
- APB qualifiers: wr = PSEL & PENABLE & PWRITE; rd = PSEL & PENABLE & ~PWRITE.
- Register map:
  - 0x00 TXDATA (W): push PWDATA.
  - 0x04 RXDATA (R): pop; PRDATA = head.
  - 0x08 CTRL1 (RW): baud_val[7:0].
  - 0x0C CTRL2 (RW): [7:3] baud_val[12:8], [2] odd_n_even, [1] parity_en, [0] bit8.
  - 0x10 STATUS: [0] TX not full, [1] RX not empty, [2] PERR, [3] OVF, [4] FERR, [5] TX empty, [6] RXTO, [7] RX level >= WMARK. Bits 2,3,4,6 are sticky, write-1-to-clear.
  - 0x14 CTRL3 (RW): [2:0] fraction.
  - 0x18 IEN (RW): enable bits aligned to STATUS[7:0].
  - 0x1C TXLVL (R): TX level.
  - 0x20 RXLVL (R): RX level.
  - 0x24 WMARK (RW): RX watermark; reset value 1.
  - 0x28 TIMEOUT (RW): reset value 0, which disables the timeout.
  - Unmapped addresses read 0; writes to them are ignored.
- FIFO rules (both FIFOs):
  - Push is accepted if not full, or if a pop occurs in the same cycle; a push+pop on a full FIFO leaves the level unchanged.
  - Pop on empty is ignored.
  - Push+pop on empty: push accepted, pop ignored (no fall-through).
  - Pointers wrap modulo depth; level is 0..depth.
- TX path:
  - The core pops when tx_valid & tx_ready.
  - An APB write rejected as full drops the data and asserts PSLVERR.
- RX path:
  - rx_valid pushes rx_data.
  - A rejected push sets OVF and the byte is discarded.
  - PERR and FERR are set from rx_valid & error, whether or not the byte is stored.
  - Read of RXDATA when empty returns 0 with PSLVERR = 1.
- Simultaneous events: W1C and set in the same cycle: set wins.
- RX timeout:
  - Counter resets on any RX push, any RX pop, or RX empty; otherwise it increments.
  - When TIMEOUT != 0 and the counter equals {TIMEOUT, TO_SHIFT zeros}, RXTO sets and the counter holds until its next reset.
- irq = OR over (STATUS & IEN), registered with 1 cycle latency.
- FIXEDMODE = 1:
  - CTRL1/2/3 writes are ignored; reads return the fixed values.
  - parity_en = (PRG_PARITY == 1 or 2); odd_n_even = (PRG_PARITY == 1).

Decomposition:
- Package uart_apb_pkg:
  - Register offset constants.
  - STATUS bit index constants.
  - Parity encoding constants.
- One sub-module, uart_sync_fifo: parameters WIDTH and DEPTH_LOG2; ports push, pop, din, dout, full, empty, level. It is instantiated twice.

Test Plan:
- Reset, then read all registers -> STATUS = 0x21, WMARK = 1, everything else 0, irq = 0, tx_valid = 0.
- With tx_ready = 0 and TX_DEPTH_LOG2 = 4, write 17 bytes 0x00..0x10 -> the 17th gets PSLVERR = 1, TXLVL = 16. Raise tx_ready -> core receives 0x00..0x0F in order; STATUS[5] = 1 afterwards.
- Drive 17 rx_valid bytes (0xA0..0xB0) -> OVF set, RXLVL = 16. Read RXDATA 16 times -> 0xA0..0xAF. A 17th read -> 0 with PSLVERR = 1. Write 0x08 to STATUS -> OVF clears.
- With RX full, assert rx_valid and an RXDATA read in the same cycle -> level stays 16, no OVF, the new byte is last out.
- TIMEOUT = 2, TO_SHIFT = 4, IEN = 0x40, push 1 RX byte -> RXTO is set exactly 32 cycles after the push; irq rises 1 cycle later. Reading the byte does not clear RXTO; W1C 0x40 drops irq.
- Assert PRESETN low mid-transfer with TXLVL = 5 -> tx_valid = 0 immediately (asynchronously) and all levels read 0 after release.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_apb_pkg                                                 |
// | Description : Register offsets, STATUS bit indices and parity encodings    |
// |               shared by the UART APB register front-end.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_apb_pkg;

  // Word indices, i.e. PADDR[5:2]
  localparam logic [3:0] c_REG_TXDATA  = 4'h0;
  localparam logic [3:0] c_REG_RXDATA  = 4'h1;
  localparam logic [3:0] c_REG_CTRL1   = 4'h2;
  localparam logic [3:0] c_REG_CTRL2   = 4'h3;
  localparam logic [3:0] c_REG_STATUS  = 4'h4;
  localparam logic [3:0] c_REG_CTRL3   = 4'h5;
  localparam logic [3:0] c_REG_IEN     = 4'h6;
  localparam logic [3:0] c_REG_TXLVL   = 4'h7;
  localparam logic [3:0] c_REG_RXLVL   = 4'h8;
  localparam logic [3:0] c_REG_WMARK   = 4'h9;
  localparam logic [3:0] c_REG_TIMEOUT = 4'hA;

  localparam int c_ST_TXNF  = 0;
  localparam int c_ST_RXNE  = 1;
  localparam int c_ST_PERR  = 2;
  localparam int c_ST_OVF   = 3;
  localparam int c_ST_FERR  = 4;
  localparam int c_ST_TXE   = 5;
  localparam int c_ST_RXTO  = 6;
  localparam int c_ST_WMARK = 7;

  localparam int c_PAR_NONE = 0;
  localparam int c_PAR_ODD  = 1;
  localparam int c_PAR_EVEN = 2;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                               |
// | Description : Single-clock FIFO, power-of-two depth, no fall-through.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign full      = (r_level == c_FULL_LVL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  // A pop frees a slot this cycle, so a push into a full FIFO is still accepted
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_uart_fifo_regs.sv
// +----------------------------------------------------------------------------+
// | Module      : apb_uart_fifo_regs                                           |
// | Description : APB3 register front-end for the UART core: TX/RX FIFOs,      |
// |               sticky error flags, RX idle timeout and maskable irq.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module apb_uart_fifo_regs
  import uart_apb_pkg::*;
#(
  parameter int TX_DEPTH_LOG2  = 4,
  parameter int RX_DEPTH_LOG2  = 4,
  parameter int TO_SHIFT       = 4,
  parameter int FIXEDMODE      = 0,
  parameter int BAUD_VALUE     = 0,
  parameter int BAUD_VAL_FRCTN = 0,
  parameter int PRG_BIT8       = 0,
  parameter int PRG_PARITY     = 0
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic [5:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PWDATA,
  output logic [7:0]  PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_parity_err,
  input  logic        rx_framing_err,
  output logic [12:0] baud_val,
  output logic [2:0]  baudval_fraction,
  output logic        bit8,
  output logic        parity_en,
  output logic        odd_n_even,
  output logic        irq
);

  localparam int c_TO_W = 8 + TO_SHIFT;

  // In fixed mode the config registers reset to the parameters and never change
  localparam logic [12:0] c_BAUD_RST = (FIXEDMODE != 0) ? 13'(BAUD_VALUE) : 13'd0;
  localparam logic [2:0]  c_FRAC_RST = (FIXEDMODE != 0) ? 3'(BAUD_VAL_FRCTN) : 3'd0;
  localparam logic        c_BIT8_RST = (FIXEDMODE != 0) && (PRG_BIT8 != 0);
  localparam logic        c_PEN_RST  = (FIXEDMODE != 0) &&
                                       (PRG_PARITY == c_PAR_ODD || PRG_PARITY == c_PAR_EVEN);
  localparam logic        c_ODD_RST  = (FIXEDMODE != 0) && (PRG_PARITY == c_PAR_ODD);

  logic                   w_wr;
  logic                   w_rd;
  logic                   w_cfg_we;
  logic [3:0]             w_addr;
  logic                   w_unused;

  logic                   w_tx_push;
  logic                   w_tx_pop;
  logic                   w_tx_full;
  logic                   w_tx_empty;
  logic [TX_DEPTH_LOG2:0] w_tx_level;

  logic                   w_rx_pop;
  logic                   w_rx_full;
  logic                   w_rx_empty;
  logic [7:0]             w_rx_dout;
  logic [RX_DEPTH_LOG2:0] w_rx_level;

  logic                   w_ovf_set;
  logic                   w_rx_push_ok;
  logic [7:0]             w_clr;
  logic [7:0]             w_status;
  logic [7:0]             w_rdata;

  logic [c_TO_W-1:0]      w_to_target;
  logic [c_TO_W-1:0]      w_to_inc;
  logic                   w_to_clr;
  logic                   w_to_en;
  logic                   w_to_hold;
  logic                   w_rxto_set;

  logic [12:0]            r_baud;
  logic [2:0]             r_frac;
  logic                   r_bit8;
  logic                   r_par_en;
  logic                   r_odd;
  logic [7:0]             r_ien;
  logic [7:0]             r_wmark;
  logic [7:0]             r_timeout;
  logic                   r_perr;
  logic                   r_ovf;
  logic                   r_ferr;
  logic                   r_rxto;
  logic [c_TO_W-1:0]      r_to_cnt;
  logic                   r_irq;

  assign w_wr     = PSEL & PENABLE & PWRITE;
  assign w_rd     = PSEL & PENABLE & ~PWRITE;
  assign w_addr   = PADDR[5:2];
  assign w_cfg_we = w_wr & (FIXEDMODE == 0);
  assign w_unused = &{1'b0, PADDR[1:0]};

  assign w_tx_push = w_wr & (w_addr == c_REG_TXDATA);
  assign w_tx_pop  = tx_valid & tx_ready;
  assign w_rx_pop  = w_rd & (w_addr == c_REG_RXDATA);

  uart_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (PWDATA),
    .dout  (tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .level (w_tx_level)
  );

  uart_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .push  (rx_valid),
    .pop   (w_rx_pop),
    .din   (rx_data),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .level (w_rx_level)
  );

  assign tx_valid     = ~w_tx_empty;
  assign w_ovf_set    = rx_valid & w_rx_full & ~w_rx_pop;
  assign w_rx_push_ok = rx_valid & ~w_ovf_set;
  assign w_clr        = (w_wr && w_addr == c_REG_STATUS) ? PWDATA : 8'h00;

  assign w_to_target = c_TO_W'(r_timeout) << TO_SHIFT;
  assign w_to_inc    = r_to_cnt + 1'b1;
  assign w_to_clr    = w_rx_push_ok | w_rx_pop | w_rx_empty;
  assign w_to_en     = (r_timeout != 8'h00);
  assign w_to_hold   = w_to_en & (r_to_cnt == w_to_target);
  // Fire on the edge where the count reaches the target, then hold there
  assign w_rxto_set  = ~w_to_clr & w_to_en & ~w_to_hold & (w_to_inc == w_to_target);

  always_comb begin
    w_status              = 8'h00;
    w_status[c_ST_TXNF]   = ~w_tx_full;
    w_status[c_ST_RXNE]   = ~w_rx_empty;
    w_status[c_ST_PERR]   = r_perr;
    w_status[c_ST_OVF]    = r_ovf;
    w_status[c_ST_FERR]   = r_ferr;
    w_status[c_ST_TXE]    = w_tx_empty;
    w_status[c_ST_RXTO]   = r_rxto;
    w_status[c_ST_WMARK]  = (8'(w_rx_level) >= r_wmark);
  end

  always_comb begin
    w_rdata = 8'h00;
    if (w_rd) begin
      case (w_addr)
        c_REG_RXDATA:  w_rdata = w_rx_empty ? 8'h00 : w_rx_dout;
        c_REG_CTRL1:   w_rdata = r_baud[7:0];
        c_REG_CTRL2:   w_rdata = {r_baud[12:8], r_odd, r_par_en, r_bit8};
        c_REG_STATUS:  w_rdata = w_status;
        c_REG_CTRL3:   w_rdata = {5'b00000, r_frac};
        c_REG_IEN:     w_rdata = r_ien;
        c_REG_TXLVL:   w_rdata = 8'(w_tx_level);
        c_REG_RXLVL:   w_rdata = 8'(w_rx_level);
        c_REG_WMARK:   w_rdata = r_wmark;
        c_REG_TIMEOUT: w_rdata = r_timeout;
        default:       w_rdata = 8'h00;
      endcase
    end
  end

  assign PRDATA  = w_rdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = (w_tx_push & w_tx_full & ~w_tx_pop) | (w_rx_pop & w_rx_empty);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_baud    <= c_BAUD_RST;
      r_frac    <= c_FRAC_RST;
      r_bit8    <= c_BIT8_RST;
      r_par_en  <= c_PEN_RST;
      r_odd     <= c_ODD_RST;
      r_ien     <= 8'h00;
      r_wmark   <= 8'h01;
      r_timeout <= 8'h00;
      r_perr    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ferr    <= 1'b0;
      r_rxto    <= 1'b0;
      r_to_cnt  <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_cfg_we && w_addr == c_REG_CTRL1) r_baud[7:0] <= PWDATA;
      if (w_cfg_we && w_addr == c_REG_CTRL2) begin
        r_baud[12:8] <= PWDATA[7:3];
        r_odd        <= PWDATA[2];
        r_par_en     <= PWDATA[1];
        r_bit8       <= PWDATA[0];
      end
      if (w_cfg_we && w_addr == c_REG_CTRL3)   r_frac    <= PWDATA[2:0];
      if (w_wr && w_addr == c_REG_IEN)         r_ien     <= PWDATA;
      if (w_wr && w_addr == c_REG_WMARK)       r_wmark   <= PWDATA;
      if (w_wr && w_addr == c_REG_TIMEOUT)     r_timeout <= PWDATA;

      // Set has priority over write-1-to-clear
      r_perr <= (rx_valid & rx_parity_err)  | (r_perr & ~w_clr[c_ST_PERR]);
      r_ferr <= (rx_valid & rx_framing_err) | (r_ferr & ~w_clr[c_ST_FERR]);
      r_ovf  <= w_ovf_set                   | (r_ovf  & ~w_clr[c_ST_OVF]);
      r_rxto <= w_rxto_set                  | (r_rxto & ~w_clr[c_ST_RXTO]);

      if (w_to_clr)        r_to_cnt <= '0;
      else if (!w_to_hold) r_to_cnt <= w_to_inc;

      r_irq <= |(w_status & r_ien);
    end
  end

  assign baud_val         = r_baud;
  assign baudval_fraction = r_frac;
  assign bit8             = r_bit8;
  assign parity_en        = r_par_en;
  assign odd_n_even       = r_odd;
  assign irq              = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_apb_uart_fifo_regs.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_uart_fifo_regs                                        |
// | Description : Directed, table-driven self-checking bench for the UART      |
// |               APB register front-end.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_apb_uart_fifo_regs;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [5:0]  PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PWDATA = '0;
  logic [7:0]  PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_parity_err = 1'b0;
  logic        rx_framing_err = 1'b0;
  logic [12:0] baud_val;
  logic [2:0]  baudval_fraction;
  logic        bit8;
  logic        parity_en;
  logic        odd_n_even;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_uart_fifo_regs #(
    .TX_DEPTH_LOG2  (4),
    .RX_DEPTH_LOG2  (4),
    .TO_SHIFT       (4),
    .FIXEDMODE      (0),
    .BAUD_VALUE     (0),
    .BAUD_VAL_FRCTN (0),
    .PRG_BIT8       (0),
    .PRG_PARITY     (0)
  ) dut (
    .PCLK             (PCLK),
    .PRESETN          (PRESETN),
    .PADDR            (PADDR),
    .PSEL             (PSEL),
    .PENABLE          (PENABLE),
    .PWRITE           (PWRITE),
    .PWDATA           (PWDATA),
    .PRDATA           (PRDATA),
    .PREADY           (PREADY),
    .PSLVERR          (PSLVERR),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_parity_err    (rx_parity_err),
    .rx_framing_err   (rx_framing_err),
    .baud_val         (baud_val),
    .baudval_fraction (baudval_fraction),
    .bit8             (bit8),
    .parity_en        (parity_en),
    .odd_n_even       (odd_n_even),
    .irq              (irq)
  );

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp_d;
    logic       exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_wr(input logic [5:0] a, input logic [7:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    #2 err = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [5:0] a, output logic [7:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick();
    PENABLE = 1'b1;
    #2 begin d = PRDATA; err = PSLVERR; end
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [7:0] exp_d,
                        input logic exp_err);
    logic [7:0] d;
    logic       e;
    apb_rd(a, d, e);
    chk({name, "_data"}, d, exp_d);
    chk({name, "_err"}, e, exp_err);
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic pe, input logic fe);
    rx_valid = 1'b1; rx_data = d; rx_parity_err = pe; rx_framing_err = fe;
    tick();
    rx_valid = 1'b0; rx_parity_err = 1'b0; rx_framing_err = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       e;

    // Reset reads, then config register write/read-back
    vt.push_back('{1'b0, 6'h00, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h04, 8'h00, 8'h00, 1'b1});
    vt.push_back('{1'b0, 6'h08, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h0C, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h10, 8'h00, 8'h21, 1'b0});
    vt.push_back('{1'b0, 6'h14, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h18, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h1C, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h20, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h24, 8'h00, 8'h01, 1'b0});
    vt.push_back('{1'b0, 6'h28, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h2C, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h3C, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b1, 6'h08, 8'h5A, 8'h00, 1'b0});
    vt.push_back('{1'b1, 6'h0C, 8'hAB, 8'h00, 1'b0});
    vt.push_back('{1'b1, 6'h14, 8'hFF, 8'h00, 1'b0});
    vt.push_back('{1'b1, 6'h3C, 8'h77, 8'h00, 1'b0});
    vt.push_back('{1'b0, 6'h08, 8'h00, 8'h5A, 1'b0});
    vt.push_back('{1'b0, 6'h0C, 8'h00, 8'hAB, 1'b0});
    vt.push_back('{1'b0, 6'h14, 8'h00, 8'h07, 1'b0});
    vt.push_back('{1'b0, 6'h3C, 8'h00, 8'h00, 1'b0});

    tick(); tick();
    #2 PRESETN = 1'b1;
    tick();

    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_prdata", PRDATA, 8'h00);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) begin
        apb_wr(vt[i].addr, vt[i].data, e);
        chk($sformatf("vec%0d_werr", i), e, vt[i].exp_err);
      end else begin
        apb_rd(vt[i].addr, d, e);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_d);
        chk($sformatf("vec%0d_rerr", i), e, vt[i].exp_err);
      end
    end

    chk("cfg_baud", baud_val, 13'h155A);
    chk("cfg_frac", baudval_fraction, 3'd7);
    chk("cfg_bit8", bit8, 1'b1);
    chk("cfg_par_en", parity_en, 1'b1);
    chk("cfg_odd", odd_n_even, 1'b0);

    // TX fill past full with the core stalled, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      apb_wr(6'h00, 8'(i), e);
      chk($sformatf("tx_push%0d_err", i), e, (i == 16));
    end
    rd_chk("tx_lvl_full", 6'h1C, 8'd16, 1'b0);
    chk("tx_valid_full", tx_valid, 1'b1);
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("tx_out%0d", k), tx_data, 8'(k));
      chk($sformatf("tx_valid%0d", k), tx_valid, 1'b1);
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_valid_drained", tx_valid, 1'b0);
    rd_chk("tx_status_empty", 6'h10, 8'h21, 1'b0);
    rd_chk("tx_lvl_empty", 6'h1C, 8'd0, 1'b0);

    // RX overflow
    for (int i = 0; i < 17; i++) rx_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    rd_chk("rx_status_ovf", 6'h10, 8'hAB, 1'b0);
    rd_chk("rx_lvl_full", 6'h20, 8'd16, 1'b0);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("rx_pop%0d", i), 6'h04, 8'hA0 + 8'(i), 1'b0);
    rd_chk("rx_pop_empty", 6'h04, 8'h00, 1'b1);
    apb_wr(6'h10, 8'h08, e);
    rd_chk("rx_ovf_cleared", 6'h10, 8'h21, 1'b0);

    // Parity / framing flags and set-over-clear priority
    rx_byte(8'h55, 1'b1, 1'b1);
    rd_chk("rx_status_err", 6'h10, 8'hB7, 1'b0);
    apb_wr(6'h10, 8'h14, e);
    rd_chk("rx_err_cleared", 6'h10, 8'hA3, 1'b0);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 6'h10; PWDATA = 8'h04;
    tick();
    PENABLE = 1'b1; rx_valid = 1'b1; rx_parity_err = 1'b1; rx_data = 8'h66;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rx_valid = 1'b0; rx_parity_err = 1'b0;
    rd_chk("set_wins", 6'h10, 8'hA7, 1'b0);
    apb_wr(6'h10, 8'h04, e);
    rd_chk("perr_cleared", 6'h10, 8'hA3, 1'b0);
    rd_chk("rx_pop_55", 6'h04, 8'h55, 1'b0);
    rd_chk("rx_pop_66", 6'h04, 8'h66, 1'b0);

    // Push and pop on a full RX FIFO in the same cycle
    for (int i = 0; i < 16; i++) rx_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 6'h04;
    tick();
    PENABLE = 1'b1; rx_valid = 1'b1; rx_data = 8'hD0;
    #2 begin d = PRDATA; e = PSLVERR; end
    chk("simul_pop_data", d, 8'hC0);
    chk("simul_pop_err", e, 1'b0);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
    rd_chk("simul_lvl", 6'h20, 8'd16, 1'b0);
    rd_chk("simul_no_ovf", 6'h10, 8'hA3, 1'b0);
    for (int i = 1; i < 16; i++) rd_chk($sformatf("simul_pop%0d", i), 6'h04, 8'hC0 + 8'(i), 1'b0);
    rd_chk("simul_last", 6'h04, 8'hD0, 1'b0);
    rd_chk("simul_lvl_empty", 6'h20, 8'd0, 1'b0);

    // RX idle timeout: TIMEOUT=2 -> 32 cycles
    apb_wr(6'h28, 8'h02, e);
    apb_wr(6'h18, 8'h40, e);
    rx_byte(8'h77, 1'b0, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 6'h10;
    for (int k = 1; k <= 33; k++) begin
      tick();
      chk($sformatf("rxto_k%0d", k), PRDATA[6], (k >= 32));
      chk($sformatf("irq_k%0d", k), irq, (k >= 33));
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    rd_chk("rxto_pop", 6'h04, 8'h77, 1'b0);
    rd_chk("rxto_sticky", 6'h10, 8'h61, 1'b0);
    chk("irq_held", irq, 1'b1);
    apb_wr(6'h10, 8'h40, e);
    tick();
    chk("irq_dropped", irq, 1'b0);
    rd_chk("rxto_cleared", 6'h10, 8'h21, 1'b0);
    apb_wr(6'h28, 8'h00, e);
    apb_wr(6'h18, 8'h00, e);

    // Watermark
    apb_wr(6'h24, 8'h02, e);
    rx_byte(8'h11, 1'b0, 1'b0);
    rd_chk("wmark_below", 6'h10, 8'h23, 1'b0);
    rx_byte(8'h22, 1'b0, 1'b0);
    rd_chk("wmark_reached", 6'h10, 8'hA3, 1'b0);
    rd_chk("wmark_pop1", 6'h04, 8'h11, 1'b0);
    rd_chk("wmark_pop2", 6'h04, 8'h22, 1'b0);

    // Asynchronous reset in the middle of a TX backlog
    for (int i = 0; i < 5; i++) apb_wr(6'h00, 8'h30 + 8'(i), e);
    rd_chk("pre_rst_txlvl", 6'h1C, 8'd5, 1'b0);
    chk("pre_rst_tx_valid", tx_valid, 1'b1);
    #2 PRESETN = 1'b0;
    #1;
    chk("async_rst_tx_valid", tx_valid, 1'b0);
    chk("async_rst_irq", irq, 1'b0);
    tick(); tick();
    #2 PRESETN = 1'b1;
    tick();
    rd_chk("post_rst_txlvl", 6'h1C, 8'd0, 1'b0);
    rd_chk("post_rst_rxlvl", 6'h20, 8'd0, 1'b0);
    rd_chk("post_rst_status", 6'h10, 8'h21, 1'b0);
    rd_chk("post_rst_ctrl2", 6'h0C, 8'h00, 1'b0);
    rd_chk("post_rst_wmark", 6'h24, 8'h01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
